uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer directly upstream of the UART transmit path.
- Accepts bursts of bytes from a host-side producer, stores them in a circular FIFO, and drains them one at a time into the UART's din/wr_en/wr_rdy interface.
- Lets firmware-side logic queue a full message without polling the transmitter per byte.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, 4, address width = log2(DEPTH).
- BUSY_WAIT, 3, max cycles to wait for uart_wr_rdy to fall after a launch before proceeding anyway.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- push_data  in  8  byte to enqueue
- push_en  in  1  enqueue strobe, one byte per cycle while high
- clear  in  1  synchronous flush of FIFO contents and sticky flags
- full  out  1  FIFO holds DEPTH bytes
- empty  out  1  FIFO holds 0 bytes
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; set when push_en arrives while full
- uart_din  out  8  byte presented to the UART transmitter
- uart_wr_en  out  1  single-cycle launch strobe to the UART transmitter
- uart_wr_rdy  in  1  transmitter idle / able to accept a byte

Behaviour:
- Reset (rst_n low, async):
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0.
  - uart_wr_en = 0, uart_din = 8'h00, FSM = IDLE.
  - Reset mid-transmission discards all queued bytes; the byte already handed to the UART is not recalled.
- Storage:
  - DEPTH x 8 register array.
  - Pointers are AW bits and wrap modulo DEPTH.
  - count is tracked separately: full = (count == DEPTH), empty = (count == 0).
- Push:
  - push_en && !full: mem[wr_ptr] <= push_data, wr_ptr++.
  - push_en && full: byte dropped, overflow <= 1, no pointer or count change.
- Pop:
  - Occurs only on the FSM IDLE -> LAUNCH transition: uart_din <= mem[rd_ptr], rd_ptr++.
- Simultaneous push and pop in one cycle: count unchanged; allowed even when full, because the pop frees the slot in the same cycle.
- FSM states:
  - IDLE: if !empty && uart_wr_rdy -> LAUNCH, popping the head byte into uart_din.
  - LAUNCH: uart_wr_en = 1 for exactly this cycle, uart_din stable; -> WAIT_BUSY, timer = 0.
  - WAIT_BUSY: if !uart_wr_rdy -> WAIT_DONE; else timer++, and when timer == BUSY_WAIT-1 -> WAIT_DONE.
  - WAIT_DONE: when uart_wr_rdy = 1 -> IDLE.
- Timing:
  - uart_wr_en is high only in LAUNCH, never two consecutive cycles.
  - Minimum spacing between launches is 4 cycles.
  - Latency from a push into an empty FIFO (UART idle) to uart_wr_en high is 2 cycles: push cycle, then IDLE pops, then LAUNCH.
- uart_din holds the last launched byte until the next pop.
- clear:
  - Resets pointers, count and overflow in the same clock.
  - FSM returns to IDLE only from IDLE or WAIT_DONE; a launch in progress completes normally.
  - clear has priority over a simultaneous push; that push is discarded.
- Outputs are registered; full, empty and count are updated the cycle after the causing edge.

Test Plan:
- Single byte: UART model with wr_rdy=1 that drops wr_rdy 1 cycle after wr_en for 10 cycles. push 8'hA5 -> uart_wr_en pulses once, 2 cycles after push, with uart_din=8'hA5; empty returns to 1.
- Burst order: push 8'h01..8'h05 back-to-back -> five wr_en pulses carrying 01,02,03,04,05 in order; each pulse at least 4 cycles apart and only after wr_rdy returned high.
- Full/overflow (DEPTH=16): hold wr_rdy=0, push 17 bytes -> full=1 after 16 and count=16; overflow=1 after the 17th; wr_en never asserts. Release wr_rdy -> exactly 16 bytes drain.
- Wrap-around: 3 rounds of push 10 / drain 10 -> pointers wrap; all 30 bytes are emitted in order with no duplicates.
- Missing busy response: UART model keeps wr_rdy=1 throughout. push 2 bytes -> FSM exits WAIT_BUSY after BUSY_WAIT cycles; both bytes are launched.
- Reset/clear mid-operation:
  - With 6 bytes queued, pulse rst_n low -> immediately count=0, empty=1, wr_en=0; no further launches.
  - Repeat with clear during WAIT_DONE -> the current byte completes; no further wr_en pulses.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that drains one byte at a time into a UART transmitter
// using a launch / wait-busy / wait-done handshake on uart_wr_rdy.
module uart_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int BUSY_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    push_data,
  input  logic          push_en,
  input  logic          clear,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    uart_din,
  output logic          uart_wr_en,
  input  logic          uart_wr_rdy
);
  localparam int TW = $clog2(BUSY_WAIT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ovf_q;
  logic [7:0]      din_q;
  logic            pop, push;
  assign full       = count_q == (AW+1)'(DEPTH);
  assign empty      = count_q == '0;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign uart_din   = din_q;
  assign uart_wr_en = state_q == LAUNCH;
  // A pop frees a slot in the same cycle, so a push while full is still accepted then.
  assign pop  = state_q == IDLE && !empty && uart_wr_rdy && !clear;
  assign push = push_en && !clear && (!full || pop);
  assign count_d = clear ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:      state_d = pop ? LAUNCH : IDLE;
      LAUNCH: begin
        state_d = WAIT_BUSY;
        timer_d = '0;
      end
      WAIT_BUSY: begin
        state_d = (!uart_wr_rdy || timer_q == TW'(BUSY_WAIT - 1)) ? WAIT_DONE : WAIT_BUSY;
        timer_d = timer_q + 1'b1;
      end
      WAIT_DONE: state_d = (clear || uart_wr_rdy) ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      din_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      wr_ptr_q <= clear ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_q <= clear ? '0 : rd_ptr_q + AW'(pop);
      ovf_q    <= !clear && (ovf_q || (push_en && full && !pop));
      if (pop) din_q <= mem_q[rd_ptr_q];
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench with a queue-based FIFO model and a simple UART responder.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int BUSY_WAIT = 3;
  logic clk = 0, rst_n = 0, push_en = 0, clear = 0;
  logic [7:0] push_data = 0;
  logic full, empty, overflow, uart_wr_en, uart_wr_rdy;
  logic [AW:0] count;
  logic [7:0] uart_din;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_launch = 0, last_cyc = 0, last_gap = 0, push_cyc = 0;
  int mode = 0, busy = 0;
  logic rdy_prev = 1, rdy_q = 1, exp_ovf = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .push_data(push_data), .push_en(push_en), .clear(clear),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .uart_din(uart_din), .uart_wr_en(uart_wr_en), .uart_wr_rdy(uart_wr_rdy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign uart_wr_rdy = rdy_q;

  // UART responder: mode 0 goes busy for 10 cycles one cycle after a launch,
  // mode 1 holds wr_rdy low, mode 2 never reports busy.
  always @(posedge clk) begin
    if (mode == 1) rdy_q <= 0;
    else if (mode == 2) rdy_q <= 1;
    else if (uart_wr_en) begin rdy_q <= 0; busy <= 10; end
    else if (busy > 0) begin busy <= busy - 1; rdy_q <= (busy == 1); end
    else rdy_q <= 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && uart_wr_en) begin
      chk("launch_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("din_order", uart_din, exp_q.pop_front());
      chk("rdy_before_launch", rdy_prev, 1);
      if (n_launch > 0) begin
        last_gap = cyc - last_cyc;
        chk("launch_gap_ge4", last_gap >= 4, 1);
      end
      last_cyc = cyc;
      n_launch++;
    end
    rdy_prev = uart_wr_rdy;
  end

  task automatic push_byte(input logic [7:0] d);
    push_data = d;
    push_en = 1;
    push_cyc = cyc;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovf = 1;
    @(negedge clk);
    push_en = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !empty) && t < 2000) begin @(negedge clk); t++; end
    chk("drain_in_time", t < 2000, 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input int c);
    chk({tag, "_count"}, count, c);
    chk({tag, "_empty"}, empty, c == 0);
    chk({tag, "_full"}, full, c == DEPTH);
    chk({tag, "_overflow"}, overflow, exp_ovf);
  endtask

  initial begin
    int base, t;
    #12;
    check_status("reset", 0);
    chk("reset_wr_en", uart_wr_en, 0);
    chk("reset_din", uart_din, 8'h00);
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);

    base = n_launch;
    push_byte(8'hA5);
    drain();
    chk("single_launches", n_launch - base, 1);
    chk("single_latency", last_cyc - push_cyc, 2);
    check_status("single_after", 0);

    base = n_launch;
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    drain();
    chk("burst_launches", n_launch - base, 5);

    mode = 1;
    repeat (3) @(negedge clk);
    base = n_launch;
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
    check_status("fill16", DEPTH);
    push_byte(8'($urandom));
    chk("overflow_model", exp_ovf, 1);
    check_status("fill17", DEPTH);
    repeat (5) @(negedge clk);
    chk("held_no_launch", n_launch - base, 0);
    mode = 0;
    drain();
    chk("full_drain_launches", n_launch - base, DEPTH);

    for (int r = 0; r < 3; r++) begin
      base = n_launch;
      for (int i = 0; i < 10; i++) push_byte(8'($urandom));
      drain();
      chk("wrap_round_launches", n_launch - base, 10);
    end

    mode = 2;
    repeat (2) @(negedge clk);
    base = n_launch;
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    drain();
    chk("nobusy_launches", n_launch - base, 2);
    chk("nobusy_gap", last_gap, BUSY_WAIT + 3);

    mode = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    check_status("queued6", 6);
    #2 rst_n = 0;
    exp_q.delete();
    exp_ovf = 0;
    #1;
    check_status("async_reset", 0);
    chk("async_reset_wr_en", uart_wr_en, 0);
    @(negedge clk); rst_n = 1;
    base = n_launch;
    mode = 0;
    repeat (30) @(negedge clk);
    chk("after_reset_no_launch", n_launch - base, 0);

    mode = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    base = n_launch;
    mode = 0;
    t = 0;
    while (n_launch == base && t < 50) begin @(negedge clk); t++; end
    chk("clear_first_launch_seen", t < 50, 1);
    repeat (2) @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    exp_q.delete();
    check_status("clear_wait_done", 0);
    repeat (40) @(negedge clk);
    chk("clear_single_launch", n_launch - base, 1);

    mode = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
    check_status("refill", DEPTH);
    clear = 1; push_en = 1; push_data = 8'h3C;
    @(negedge clk);
    clear = 0; push_en = 0;
    exp_q.delete();
    exp_ovf = 0;
    check_status("clear_vs_push", 0);
    base = n_launch;
    mode = 0;
    repeat (30) @(negedge clk);
    chk("after_clear_no_launch", n_launch - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
